// File: rtl/mult_seq_param.sv
// Parametrised sequential shift-add multiplier with per-operation signed/unsigned mode.
// Optional MULT_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    COUNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t           state_reg;
  logic [PW-1:0]    acc_reg;
  logic [PW-1:0]    mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    count_reg;
  logic             sign_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [PW-1:0]    product_reg;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             term;
  logic [PW-1:0]    result_next;

  // Magnitude in WIDTH unsigned bits: the most negative value maps to 2^(WIDTH-1) exactly.
  assign neg_a = signed_mode & a[WIDTH-1];
  assign neg_b = signed_mode & b[WIDTH-1];
  assign mag_a = neg_a ? (~a + ONE_W) : a;
  assign mag_b = neg_b ? (~b + ONE_W) : b;

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign term = (count_reg == COUNT_LAST) || (mplier_reg == '0);
`else
  assign term = (count_reg == COUNT_LAST);
`endif

  assign result_next = sign_reg ? (~acc_reg + ONE_P) : acc_reg;

  // Outputs are registered: product and done are loaded on the edge that enters FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      sign_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg  <= CALC;
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_b;
            acc_reg    <= '0;
            count_reg  <= '0;
            sign_reg   <= neg_a ^ neg_b;
            busy_reg   <= 1'b1;
          end
        end
        CALC: begin
          if (term) begin
            state_reg   <= FINISH;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            product_reg <= result_next;
          end else begin
            if (mplier_reg[0]) begin
              acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
          end
        end
        FINISH: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule
